// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
// IMEM_LOADER_CHECKSUM_EN adds the CHECK state used for the trailing checksum byte.
package imem_loader_pkg;

  localparam int unsigned BYTE_IDX_W        = 2;
  localparam int unsigned LEN_W             = 16;
  localparam logic [7:0]  SYNC_BYTE_DEFAULT = 8'hA5;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LEN_LO = 3'd1,
    ST_LEN_HI = 3'd2,
    ST_DATA   = 3'd3,
    ST_WRITE  = 3'd4,
    ST_DONE   = 3'd5,
    ST_ERROR  = 3'd6
`ifdef IMEM_LOADER_CHECKSUM_EN
    , ST_CHECK = 3'd7
`endif
  } state_e;

  // States in which the inter-byte timeout is allowed to advance.
  function automatic logic is_timed(input state_e s);
    logic timed;
    timed = (s == ST_LEN_LO) || (s == ST_LEN_HI) || (s == ST_DATA);
`ifdef IMEM_LOADER_CHECKSUM_EN
    timed = timed || (s == ST_CHECK);
`endif
    return timed;
  endfunction

endpackage

// File: rtl/imem_loader_timeout.sv
// Inter-byte watchdog: counts enabled cycles since the last clear and flags
// expiry once TIMEOUT_CYCLES-1 is reached (the count then holds).
module loader_timeout #(
  parameter int unsigned TIMEOUT_CYCLES = 100000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired_c
);

  localparam int unsigned   CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en && (count != LAST)) begin
      count <= count + CNT_W'(1);
    end
  end

  assign expired_c = (count == LAST);

endmodule

// File: rtl/imem_loader.sv
// Boot loader: frames A5 | len_lo len_hi | words (LSB first) into instruction memory.
// Define IMEM_LOADER_CHECKSUM_EN to require a trailing mod-256 checksum byte.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int unsigned ADDR_W         = 8,
  parameter logic [7:0]  SYNC_BYTE      = SYNC_BYTE_DEFAULT,
  parameter int unsigned TIMEOUT_CYCLES = 100000
) (
  input  logic              clk,
  input  logic              Reset,
  input  logic [7:0]        RxData,
  input  logic              RxValid,
  output logic              RxReady,
  output logic              MemWE,
  output logic [ADDR_W-1:0] MemAddr,
  output logic [31:0]       MemData,
  output logic              CpuHold,
  output logic              Done,
  output logic              Error,
  output logic [LEN_W-1:0]  WordCount
);

  localparam int unsigned MAX_WORDS = 1 << ADDR_W;

  state_e                state_q, state_d;
  logic [BYTE_IDX_W-1:0] idx_q, idx_d;
  logic [LEN_W-1:0]      len_q, len_d;
  logic [23:0]           word_q, word_d;
  logic                  we_q, we_d;
  logic [ADDR_W-1:0]     addr_q, addr_d;
  logic [31:0]           data_q, data_d;
  logic                  hold_q, hold_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;
  logic [LEN_W-1:0]      count_q, count_d;
  logic                  ready_q, ready_d;

  logic                  accept;
  logic                  expired_c;
  logic                  fin, go_done, go_err;
  logic [LEN_W-1:0]      len_n;
  logic [31:0]           word_n;

  assign accept = RxValid & ready_q;
  assign len_n  = {RxData, len_q[7:0]};
  assign word_n = {RxData, word_q};

  // Every accepted byte restarts the watchdog, including the SYNC that opens LEN_LO.
  loader_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk      (clk),
    .rst_n    (Reset),
    .clr      (accept),
    .en       (is_timed(state_q)),
    .expired_c(expired_c)
  );

`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0] sum_q;

  // Running sum of length and data bytes; cleared whenever no frame is open.
  always_ff @(posedge clk) begin
    if (!Reset) begin
      sum_q <= '0;
    end else if ((state_q == ST_IDLE) || (state_q == ST_DONE) || (state_q == ST_ERROR)) begin
      sum_q <= '0;
    end else if (accept && ((state_q == ST_LEN_LO) || (state_q == ST_LEN_HI) ||
                            (state_q == ST_DATA))) begin
      sum_q <= sum_q + RxData;
    end
  end
`endif

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    len_d   = len_q;
    word_d  = word_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    data_d  = data_q;
    hold_d  = hold_q;
    done_d  = done_q;
    err_d   = err_q;
    count_d = count_q;
    fin     = 1'b0;
    go_done = 1'b0;
    go_err  = 1'b0;

    case (state_q)
      ST_IDLE, ST_DONE, ST_ERROR: begin
        if (accept && (RxData == SYNC_BYTE)) begin
          state_d = ST_LEN_LO;
          hold_d  = 1'b1;
          done_d  = 1'b0;
          err_d   = 1'b0;
          count_d = '0;
          idx_d   = '0;
        end
      end
      ST_LEN_LO: begin
        if (accept) begin
          len_d[7:0] = RxData;
          state_d    = ST_LEN_HI;
        end
      end
      ST_LEN_HI: begin
        if (accept) begin
          len_d = len_n;
          idx_d = '0;
          if (len_n == '0) begin
            fin = 1'b1;
          end else if (32'(len_n) > MAX_WORDS) begin
            go_err = 1'b1;
          end else begin
            state_d = ST_DATA;
          end
        end
      end
      ST_DATA: begin
        if (accept) begin
          word_d = word_n[31:8];
          if (idx_q == BYTE_IDX_W'(3)) begin
            state_d = ST_WRITE;
            we_d    = 1'b1;
            addr_d  = ADDR_W'(count_q);
            data_d  = word_n;
          end else begin
            idx_d = idx_q + BYTE_IDX_W'(1);
          end
        end
      end
      ST_WRITE: begin
        count_d = count_q + LEN_W'(1);
        idx_d   = '0;
        if ((count_q + LEN_W'(1)) == len_q) begin
          fin = 1'b1;
        end else begin
          state_d = ST_DATA;
        end
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      ST_CHECK: begin
        if (accept) begin
          if (RxData == sum_q) go_done = 1'b1;
          else                 go_err  = 1'b1;
        end
      end
`endif
      default: state_d = ST_IDLE;
    endcase

    if (is_timed(state_q) && !accept && expired_c) go_err = 1'b1;

    if (fin) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
      state_d = ST_CHECK;
`else
      go_done = 1'b1;
`endif
    end

    if (go_done) begin
      state_d = ST_DONE;
      hold_d  = 1'b0;
      done_d  = 1'b1;
    end
    if (go_err) begin
      state_d = ST_ERROR;
      hold_d  = 1'b1;
      err_d   = 1'b1;
    end

    ready_d = (state_d != ST_WRITE);
  end

  always_ff @(posedge clk) begin
    if (!Reset) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      len_q   <= '0;
      word_q  <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      hold_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      count_q <= '0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      len_q   <= len_d;
      word_q  <= word_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      hold_q  <= hold_d;
      done_q  <= done_d;
      err_q   <= err_d;
      count_q <= count_d;
      ready_q <= ready_d;
    end
  end

  assign RxReady   = ready_q;
  assign MemWE     = we_q;
  assign MemAddr   = addr_q;
  assign MemData   = data_q;
  assign CpuHold   = hold_q;
  assign Done      = done_q;
  assign Error     = err_q;
  assign WordCount = count_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: framing, writes, length limits, timeout and reset.
module tb_imem_loader;

  localparam int unsigned ADDR_W = 8;
  localparam int unsigned TO     = 40;

  logic              clk = 1'b0;
  logic              reset;
  logic [7:0]        rx_data;
  logic              rx_valid;
  logic              rx_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_data;
  logic              cpu_hold;
  logic              done;
  logic              error;
  logic [15:0]       word_count;

  int checks   = 0;
  int failures = 0;
  int wr_total = 0;
  int ready_low = 0;
  int base;
  int rl;
  logic [ADDR_W-1:0] log_addr [0:63];
  logic [31:0]       log_data [0:63];

  always #5 clk = ~clk;

  imem_loader #(
    .ADDR_W        (ADDR_W),
    .SYNC_BYTE     (8'hA5),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk      (clk),
    .Reset    (reset),
    .RxData   (rx_data),
    .RxValid  (rx_valid),
    .RxReady  (rx_ready),
    .MemWE    (mem_we),
    .MemAddr  (mem_addr),
    .MemData  (mem_data),
    .CpuHold  (cpu_hold),
    .Done     (done),
    .Error    (error),
    .WordCount(word_count)
  );

  // Write log and count of not-ready cycles outside reset.
  always @(negedge clk) begin
    if (mem_we && wr_total < 64) begin
      log_addr[wr_total] = mem_addr;
      log_data[wr_total] = mem_data;
      wr_total++;
    end
    if (reset && !rx_ready) ready_low++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
    while (!rx_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) check("ready_wait", 32'(rx_ready), 32'd1);
    @(posedge clk);
    #1 rx_valid = 1'b0;
  endtask

  task automatic wait_end(input int budget);
    int n;
    n = 0;
    while (!(done || error) && n < budget) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("frame_end", 32'(done | error), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset    = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check("rst_we",    32'(mem_we),     32'd0);
    check("rst_addr",  32'(mem_addr),   32'd0);
    check("rst_data",  mem_data,        32'd0);
    check("rst_hold",  32'(cpu_hold),   32'd0);
    check("rst_done",  32'(done),       32'd0);
    check("rst_err",   32'(error),      32'd0);
    check("rst_wc",    32'(word_count), 32'd0);
    check("rst_ready", 32'(rx_ready),   32'd0);
    @(negedge clk) reset = 1'b1;
    @(posedge clk);
    #1;
    check("ready_after_reset", 32'(rx_ready), 32'd1);

    // Two-word frame.
    base = wr_total;
    rl   = ready_low;
    send_byte(8'hA5);
    check("f1_hold_in_frame", 32'(cpu_hold), 32'd1);
    send_byte(8'h02); send_byte(8'h00);
    send_byte(8'h13); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
    send_byte(8'h78); send_byte(8'h56); send_byte(8'h34); send_byte(8'h12);
`ifdef IMEM_LOADER_CHECKSUM_EN
    send_byte(8'h29);
`endif
    wait_end(10);
    check("f1_writes", 32'(wr_total - base), 32'd2);
    check("f1_addr0",  32'(log_addr[base]),     32'd0);
    check("f1_data0",  log_data[base],          32'h0000_0013);
    check("f1_addr1",  32'(log_addr[base + 1]), 32'd1);
    check("f1_data1",  log_data[base + 1],      32'h1234_5678);
    check("f1_done",   32'(done),       32'd1);
    check("f1_err",    32'(error),      32'd0);
    check("f1_hold",   32'(cpu_hold),   32'd0);
    check("f1_wc",     32'(word_count), 32'd2);
    check("f1_ready_low", 32'(ready_low - rl), 32'd2);

    // Leading garbage is ignored, then a one-word frame.
    base = wr_total;
    send_byte(8'h00); send_byte(8'hFF);
    check("f2_done_kept", 32'(done), 32'd1);
    check("f2_hold_idle", 32'(cpu_hold), 32'd0);
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h00);
    send_byte(8'hEF); send_byte(8'hBE); send_byte(8'hAD); send_byte(8'hDE);
`ifdef IMEM_LOADER_CHECKSUM_EN
    send_byte(8'h39);
`endif
    wait_end(10);
    check("f2_writes", 32'(wr_total - base), 32'd1);
    check("f2_addr",   32'(log_addr[base]), 32'd0);
    check("f2_data",   log_data[base],      32'hDEAD_BEEF);
    check("f2_wc",     32'(word_count),     32'd1);
    check("f2_done",   32'(done),           32'd1);

    // Zero-length frame.
    base = wr_total;
    send_byte(8'hA5); send_byte(8'h00); send_byte(8'h00);
`ifdef IMEM_LOADER_CHECKSUM_EN
    send_byte(8'h00);
`endif
    wait_end(10);
    check("f0_writes", 32'(wr_total - base), 32'd0);
    check("f0_done",   32'(done),       32'd1);
    check("f0_wc",     32'(word_count), 32'd0);
    check("f0_err",    32'(error),      32'd0);

    // Stalled frame hits the inter-byte timeout.
    base = wr_total;
    send_byte(8'hA5); send_byte(8'h05); send_byte(8'h00);
    send_byte(8'h11); send_byte(8'h22);
    repeat (TO - 3) @(posedge clk);
    #1;
    check("to_not_early", 32'(error),    32'd0);
    check("to_hold_wait", 32'(cpu_hold), 32'd1);
    repeat (5) @(posedge clk);
    #1;
    check("to_err",    32'(error),    32'd1);
    check("to_hold",   32'(cpu_hold), 32'd1);
    check("to_done",   32'(done),     32'd0);
    check("to_writes", 32'(wr_total - base), 32'd0);

    // Length 257 exceeds a 256-word memory.
    base = wr_total;
    send_byte(8'hA5);
    check("big_err_cleared", 32'(error), 32'd0);
    send_byte(8'h01); send_byte(8'h01);
    @(posedge clk);
    #1;
    check("big_err",    32'(error),    32'd1);
    check("big_hold",   32'(cpu_hold), 32'd1);
    check("big_done",   32'(done),     32'd0);
    check("big_writes", 32'(wr_total - base), 32'd0);

    // Reset in the middle of the third word, then reload from address 0.
    base = wr_total;
    send_byte(8'hA5); send_byte(8'h04); send_byte(8'h00);
    send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
    send_byte(8'h05); send_byte(8'h06); send_byte(8'h07); send_byte(8'h08);
    send_byte(8'h09); send_byte(8'h0A);
    check("mid_writes", 32'(wr_total - base), 32'd2);
    check("mid_wc",     32'(word_count),      32'd2);
    @(negedge clk) reset = 1'b0;
    @(posedge clk);
    #1;
    check("mid_rst_we",    32'(mem_we),     32'd0);
    check("mid_rst_addr",  32'(mem_addr),   32'd0);
    check("mid_rst_data",  mem_data,        32'd0);
    check("mid_rst_hold",  32'(cpu_hold),   32'd0);
    check("mid_rst_done",  32'(done),       32'd0);
    check("mid_rst_err",   32'(error),      32'd0);
    check("mid_rst_wc",    32'(word_count), 32'd0);
    check("mid_rst_ready", 32'(rx_ready),   32'd0);
    @(negedge clk) reset = 1'b1;
    base = wr_total;
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h00);
    send_byte(8'h44); send_byte(8'h33); send_byte(8'h22); send_byte(8'h11);
`ifdef IMEM_LOADER_CHECKSUM_EN
    send_byte(8'hAB);
`endif
    wait_end(10);
    check("re_writes", 32'(wr_total - base), 32'd1);
    check("re_addr",   32'(log_addr[base]),  32'd0);
    check("re_data",   log_data[base],       32'h1122_3344);
    check("re_done",   32'(done),            32'd1);
    check("re_wc",     32'(word_count),      32'd1);

`ifdef IMEM_LOADER_CHECKSUM_EN
    // Correct and incorrect trailing checksum.
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h00);
    send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
    send_byte(8'h0B);
    wait_end(10);
    check("cs_ok_done", 32'(done),  32'd1);
    check("cs_ok_err",  32'(error), 32'd0);
    base = wr_total;
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h00);
    send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
    send_byte(8'h0C);
    wait_end(10);
    check("cs_bad_err",    32'(error),    32'd1);
    check("cs_bad_done",   32'(done),     32'd0);
    check("cs_bad_hold",   32'(cpu_hold), 32'd1);
    check("cs_bad_writes", 32'(wr_total - base), 32'd1);
    check("cs_bad_data",   log_data[base], 32'h0403_0201);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Boot-time writer for the processor's instruction memory.
- Receives a framed byte stream from a serial receiver through a valid/ready handshake, assembles little-endian 32-bit words and writes them to consecutive word addresses.
- Holds the processor pipeline in reset (CpuHold) while a load is in progress.

Parameters:
ADDR_W, 8, instruction-memory word-address width; max image 2^ADDR_W words
SYNC_BYTE, 8'hA5, frame start marker
TIMEOUT_CYCLES, 100000, max cycles between accepted bytes inside a frame before abort

Ports:
clk  in  1  system clock, rising edge
Reset  in  1  synchronous, active-low reset
RxData  in  8  received byte
RxValid  in  1  RxData valid
RxReady  out  1  loader accepts a byte this cycle; a byte transfers when RxValid & RxReady
MemWE  out  1  instruction-memory write strobe, one-cycle pulse
MemAddr  out  ADDR_W  word address for write
MemData  out  32  word to write
CpuHold  out  1  1 = processor held in reset
Done  out  1  sticky: last frame loaded successfully
Error  out  1  sticky: last frame aborted
WordCount  out  16  words written in the current or last frame

Behaviour:
- Reset (Reset==0 at clk edge): state IDLE; MemWE=0, MemAddr=0, MemData=0, CpuHold=0, Done=0, Error=0, WordCount=0, timeout counter 0.
- RxReady=1 in every state except WRITE and except during reset.
- States: IDLE, LEN_LO, LEN_HI, DATA, WRITE, CHECK (feature only), DONE, ERROR.
- IDLE/DONE/ERROR: accepted bytes other than SYNC_BYTE are discarded.
  - SYNC_BYTE -> LEN_LO; CpuHold=1, Done=0, Error=0, WordCount=0, byte index 0.
- LEN_LO, LEN_HI: accept length low byte, then high byte (16-bit word count N).
  - After LEN_HI: N==0 -> DONE (or CHECK if feature enabled).
  - N > 2^ADDR_W -> ERROR.
  - Otherwise -> DATA.
- DATA: accepted bytes fill the word LSB first (byte index 0..3). The 4th byte -> WRITE.
- WRITE: exactly one cycle with MemWE=1, MemAddr=WordCount[ADDR_W-1:0], MemData=assembled word.
  - Next cycle: WordCount += 1, MemWE=0.
  - Latency: MemWE is high on the cycle immediately after the 4th byte is accepted.
  - If WordCount+1 == N -> DONE (CHECK if feature); else DATA with byte index 0.
- DONE: CpuHold=0, Done=1. ERROR: CpuHold=1 (processor stays halted), Error=1.
- MemAddr/MemData hold their last values when MemWE=0.
- Timeout:
  - Counter clears on every accepted byte and on entering LEN_LO.
  - Counts in LEN_LO, LEN_HI, DATA, CHECK; frozen in WRITE.
  - Reaching TIMEOUT_CYCLES-1 -> ERROR.
- SYNC_BYTE inside LEN_LO..CHECK is ordinary payload; it does not restart the frame.
- Reset mid-frame: immediate return to reset values. CpuHold drops to 0 and partially written memory is left as is.
- WordCount saturates at no limit beyond N; the length check guarantees no address wrap.

Optional Feature:
- Macro: IMEM_LOADER_CHECKSUM_EN.
- Defined:
  - Running 8-bit sum (mod 256) of all bytes after SYNC_BYTE (both length bytes plus all data bytes).
  - After the last WRITE (or after LEN_HI when N==0), state CHECK accepts one checksum byte.
  - Equal to the sum -> DONE; otherwise -> ERROR.
  - Memory has already been written either way; ERROR keeps CpuHold=1.
- Undefined: no CHECK state and no sum register; last WRITE (or N==0) goes straight to DONE.

Decomposition:
- Shared package imem_loader_pkg:
  - state enum.
  - SYNC_BYTE default.
  - byte-index width (2).
  - length width (16).
- One sub-module: loader_timeout, a TIMEOUT_CYCLES counter with clear, enable and expire outputs.
- Word assembly and FSM stay in imem_loader.

Test Plan:
- Frame A5 02 00 | 13 00 00 00 | 78 56 34 12 -> MemWE pulses at addr 0 data 32'h00000013, then addr 1 data 32'h12345678. Then Done=1, CpuHold=0, WordCount=2, RxReady=0 only in the two WRITE cycles.
- Bytes 00 FF before A5 01 00 EF BE AD DE -> leading bytes ignored; single write addr 0 data 32'hDEADBEEF.
- A5 05 00 then 2 data bytes, then RxValid low for TIMEOUT_CYCLES -> Error=1, CpuHold=1, no MemWE.
- Length 0x0101 with ADDR_W=8 (max 256) -> ERROR right after LEN_HI, zero writes.
- Reset pulled low during DATA of word 3 -> next cycle all outputs at reset values. A new frame then loads from addr 0.
- (CHECKSUM_EN) A5 01 00 01 02 03 04 + checksum 0x0B -> Done=1; same frame with 0x0C -> Error=1 after the write occurred.
